// File: rtl/mandelbrot_calc_if.sv
// mandelbrot_calc_if: point-in / result-out handshake bundle for mandelbrot_calc.
//
// Signals
//   in_vld  : point valid (upstream -> engine)
//   in_rdy  : engine ready for a point (engine -> upstream)
//   x, y    : signed s4.F coordinates of c
//   in_adr  : framebuffer address of the point
//   out_vld : result valid (engine -> downstream)
//   out_rdy : downstream ready (downstream -> engine)
//   niter   : escape iteration count
//   adr     : framebuffer address passed through from in_adr
//
// Modports
//   master : the side feeding points and taking results (coordinate generator / writer)
//   slave  : the engine itself
interface mandelbrot_calc_if #(
  parameter int FPW = 27,
  parameter int AW  = 12,
  parameter int IW  = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic signed [FPW-1:0] x;
  logic signed [FPW-1:0] y;
  logic [AW-1:0]         in_adr;
  logic                  out_vld;
  logic                  out_rdy;
  logic [IW-1:0]         niter;
  logic [AW-1:0]         adr;

  modport master (
    output in_vld, x, y, in_adr, out_rdy,
    input  in_rdy, out_vld, niter, adr
  );

  modport slave (
    input  in_vld, x, y, in_adr, out_rdy,
    output in_rdy, out_vld, niter, adr
  );
endinterface

// File: rtl/mandelbrot_calc.sv
// mandelbrot_calc: iterative fixed-point Mandelbrot escape-time engine.
//
// Accepts one point c = (x, y) with its framebuffer address, iterates
// z = z^2 + c from z = 0 until |z| escapes or MAXITER is reached, then
// presents the iteration count and the unchanged address. One point at a time.
//
// Ports
//   clk    : clock
//   rst    : asynchronous, active-high reset
//   clk_en : global clock enable; all state holds when low
//   bus    : mandelbrot_calc_if.slave (in_vld/in_rdy/x/y/in_adr, out_vld/out_rdy/niter/adr)
//
// Build option
//   MANDELBROT_CALC_MUL_REG_EN : when defined, each iteration is split into a
//   MUL cycle (registers the three products) and an ITER cycle (escape test
//   and z update from the registered products). Results are bit-identical.
module mandelbrot_calc #(
  parameter int FPW     = 27,
  parameter int AW      = 12,
  parameter int IW      = 8,
  parameter int MAXITER = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  mandelbrot_calc_if.slave bus
);

  // Number format is s4.F: 1 sign bit, 4 integer bits, F fraction bits.
  localparam int F = FPW - 5;
  localparam logic signed [FPW-1:0] TWO     = FPW'(2 << F);
  localparam logic signed [FPW-1:0] NEG_TWO = -TWO;
  localparam logic signed [FPW:0]   FOUR    = (FPW+1)'(4 << F);
  localparam logic [IW-1:0]         CNT_MAX = IW'(MAXITER);

`ifdef MANDELBROT_CALC_MUL_REG_EN
  typedef enum logic [1:0] {IDLE, ITER, DONE, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t state, state_nxt;

  logic signed [FPW-1:0] cr, ci, zr, zi;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         niter_q;
  logic [AW-1:0]         adr_q;

  // Products of the current z, each scaled back to s4.F and truncated to FPW.
  logic signed [FPW-1:0] zr2_c, zi2_c, zrzi_c;
  // Products as consumed by the escape test and update.
  logic signed [FPW-1:0] zr2_u, zi2_u, zrzi_u;
  logic signed [FPW:0]   mag2;
  logic signed [FPW-1:0] zr_nxt, zi_nxt;
  logic                  escape;

  // Full-width signed products, arithmetic shift by F, keep the low FPW bits.
  always_comb begin
    zr2_c  = FPW'(((2*FPW)'(zr) * (2*FPW)'(zr)) >>> F);
    zi2_c  = FPW'(((2*FPW)'(zi) * (2*FPW)'(zi)) >>> F);
    zrzi_c = FPW'(((2*FPW)'(zr) * (2*FPW)'(zi)) >>> F);
  end

`ifdef MANDELBROT_CALC_MUL_REG_EN
  logic signed [FPW-1:0] zr2_q, zi2_q, zrzi_q;

  // Product pipeline register, loaded only in MUL so ITER sees products of the current z.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zr2_q  <= '0;
      zi2_q  <= '0;
      zrzi_q <= '0;
    end else if (clk_en && state == MUL) begin
      zr2_q  <= zr2_c;
      zi2_q  <= zi2_c;
      zrzi_q <= zrzi_c;
    end
  end

  assign zr2_u  = zr2_q;
  assign zi2_u  = zi2_q;
  assign zrzi_u = zrzi_q;
`else
  assign zr2_u  = zr2_c;
  assign zi2_u  = zi2_c;
  assign zrzi_u = zrzi_c;
`endif

  // The abs tests fire before a square can overflow s4; the squares are only
  // trusted once both components are inside (-2, 2).
  always_comb begin
    mag2   = {zr2_u[FPW-1], zr2_u} + {zi2_u[FPW-1], zi2_u};
    escape = (zr >= TWO) || (zr <= NEG_TWO) ||
             (zi >= TWO) || (zi <= NEG_TWO) ||
             (mag2 > FOUR) || (cnt == CNT_MAX);
    zr_nxt = zr2_u - zi2_u + cr;
    zi_nxt = (zrzi_u <<< 1) + ci;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef MANDELBROT_CALC_MUL_REG_EN
      IDLE: if (bus.in_vld) state_nxt = MUL;
      MUL:  state_nxt = ITER;
      ITER: state_nxt = escape ? DONE : MUL;
`else
      IDLE: if (bus.in_vld) state_nxt = ITER;
      ITER: if (escape) state_nxt = DONE;
`endif
      DONE: if (bus.out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state only; results come straight from registers.
  always_comb begin
    bus.in_rdy  = (state == IDLE);
    bus.out_vld = (state == DONE);
    bus.niter   = niter_q;
    bus.adr     = adr_q;
  end

  // Point latch and z iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr      <= '0;
      ci      <= '0;
      zr      <= '0;
      zi      <= '0;
      cnt     <= '0;
      niter_q <= '0;
      adr_q   <= '0;
    end else if (clk_en) begin
      if (state == IDLE && bus.in_vld) begin
        cr    <= bus.x;
        ci    <= bus.y;
        adr_q <= bus.in_adr;
        zr    <= '0;
        zi    <= '0;
        cnt   <= '0;
      end else if (state == ITER) begin
        if (escape) begin
          niter_q <= cnt;
        end else begin
          zr  <= zr_nxt;
          zi  <= zi_nxt;
          cnt <= cnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_calc.sv
// tb_mandelbrot_calc: randomized self-checking bench for mandelbrot_calc.
// Points are checked against an arithmetic escape-time model; a second
// instance with MAXITER = 16 covers the reduced iteration limit.
// Honours MANDELBROT_CALC_MUL_REG_EN for the expected latency.
module tb_mandelbrot_calc;

  localparam int FPW = 27;
  localparam int F   = FPW - 5;
  localparam int AW  = 12;
  localparam int IW  = 8;
  localparam int BOUND = 4000;
  localparam longint ONE  = longint'(1) << F;
  localparam longint TWO  = 2 * ONE;
  localparam longint FOUR = 4 * ONE;

  logic clk = 0;
  logic rst = 1;
  logic clk_en = 1;
  bit   rand_en = 0;
  bit   rand_rdy = 0;

  int total = 0;
  int bad = 0;

  typedef struct {int niter; int adr;} exp_t;
  exp_t exp_q[$];
  int   edges = 0;
  int   acc_mark = 0;
  bit   seen_vld = 0;

  mandelbrot_calc_if #(.FPW(FPW), .AW(AW), .IW(IW)) bus ();
  mandelbrot_calc_if #(.FPW(FPW), .AW(AW), .IW(IW)) bus16 ();

  mandelbrot_calc #(.FPW(FPW), .AW(AW), .IW(IW), .MAXITER(255)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
  );

  mandelbrot_calc #(.FPW(FPW), .AW(AW), .IW(IW), .MAXITER(16)) dut16 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus16)
  );

  always #5 clk = ~clk;

  // Reduce to FPW-bit two's complement.
  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((longint'(1) << FPW) - 1);
    if (m >= (longint'(1) << (FPW - 1))) m -= longint'(1) << FPW;
    return m;
  endfunction

  // Escape-time reference: number of completed z updates before escape.
  function automatic int model_niter(input longint cr, input longint ci, input int maxiter);
    longint zr = 0, zi = 0, zr2, zi2, zrzi;
    for (int n = 0; n <= maxiter; n++) begin
      zr2  = wrap((zr * zr) >>> F);
      zi2  = wrap((zi * zi) >>> F);
      zrzi = wrap((zr * zi) >>> F);
      if (zr >= TWO || zr <= -TWO || zi >= TWO || zi <= -TWO ||
          zr2 + zi2 > FOUR || n == maxiter)
        return n;
      zr = wrap(zr2 - zi2 + cr);
      zi = wrap(2 * zrzi + ci);
    end
    return maxiter;
  endfunction

  function automatic int exp_latency(input int n);
`ifdef MANDELBROT_CALC_MUL_REG_EN
    return 2 * (n + 1) + 1;
`else
    return n + 2;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Offer one point and hold it until the engine takes it.
  task automatic applyStimulus(input longint xv, input longint yv, input int a);
    bit done = 0;
    bus.x = FPW'(xv);
    bus.y = FPW'(yv);
    bus.in_adr = AW'(a);
    bus.in_vld = 1;
    for (int i = 0; i < BOUND && !done; i++) begin
      @(negedge clk);
      if (clk_en && bus.in_rdy) done = 1;
      align();
    end
    bus.in_vld = 0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < BOUND && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_rdy) done = 1;
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
    align();
  endtask

  // Single point through the MAXITER=16 instance.
  task automatic runSmall(input longint xv, input longint yv, input int lit);
    bit acc = 0;
    bit got = 0;
    bus16.x = FPW'(xv);
    bus16.y = FPW'(yv);
    bus16.in_adr = AW'(7);
    bus16.in_vld = 1;
    for (int i = 0; i < BOUND && !acc; i++) begin
      @(negedge clk);
      if (clk_en && bus16.in_rdy) acc = 1;
      align();
    end
    bus16.in_vld = 0;
    for (int i = 0; i < BOUND && !got; i++) begin
      @(negedge clk);
      if (bus16.out_vld) got = 1;
    end
    checkOutput("m16_done", got, 1);
    checkOutput("m16_niter_model", bus16.niter, model_niter(xv, yv, 16));
    checkOutput("m16_niter_lit", bus16.niter, lit);
    checkOutput("m16_adr", bus16.adr, 7);
    align();
  endtask

  // Compare process: observe the outputs, then record the handshakes of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      seen_vld = 0;
    end else begin
      if (bus.out_vld) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_vld", 1, 0);
        end else begin
          checkOutput("niter", bus.niter, exp_q[0].niter);
          checkOutput("adr", bus.adr, exp_q[0].adr);
          checkOutput("in_rdy_while_done", bus.in_rdy, 0);
          if (!seen_vld) checkOutput("latency", edges - acc_mark, exp_latency(exp_q[0].niter));
        end
      end
      seen_vld = bus.out_vld;
      if (clk_en) begin
        if (bus.in_vld && bus.in_rdy) begin
          exp_t e;
          e.niter = model_niter(longint'(bus.x), longint'(bus.y), 255);
          e.adr = int'(bus.in_adr);
          exp_q.push_back(e);
          acc_mark = edges;
        end
        if (bus.out_vld && bus.out_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        edges++;
      end
    end
  end

  // Random clock-enable and downstream back-pressure.
  initial begin
    forever begin
      align();
      clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_rdy) bus.out_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #(20_000_000);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    bus.in_vld = 0; bus.x = '0; bus.y = '0; bus.in_adr = '0; bus.out_rdy = 1;
    bus16.in_vld = 0; bus16.x = '0; bus16.y = '0; bus16.in_adr = '0; bus16.out_rdy = 1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_in_rdy", bus.in_rdy, 1);
    checkOutput("rst_out_vld", bus.out_vld, 0);
    checkOutput("rst_niter", bus.niter, 0);
    checkOutput("rst_adr", bus.adr, 0);
    @(posedge clk);
    #1 rst = 0;
    align();

    // Hand-computed pins on the model.
    checkOutput("model_c00", model_niter(0, 0, 255), 255);
    checkOutput("model_c10", model_niter(ONE, 0, 255), 2);
    checkOutput("model_cm25", model_niter(-(5 * ONE) / 2, -ONE, 255), 1);
    checkOutput("model_cm1_255", model_niter(-ONE, 0, 255), 255);
    checkOutput("model_cm1_16", model_niter(-ONE, 0, 16), 16);

    // Directed points.
    applyStimulus(0, 0, 1);
    waitIdle();
    applyStimulus(ONE, 0, 2);
    waitIdle();
    applyStimulus(-ONE, 0, 3);
    waitIdle();

    // Back-pressure: result must hold while out_rdy is low.
    bus.out_rdy = 0;
    applyStimulus(-(5 * ONE) / 2, -ONE, 0);
    got = 0;
    for (int i = 0; i < BOUND && !got; i++) begin
      @(negedge clk);
      if (bus.out_vld) got = 1;
    end
    checkOutput("stall_reached", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_vld", bus.out_vld, 1);
      checkOutput("stall_niter", bus.niter, 1);
      checkOutput("stall_adr", bus.adr, 0);
      checkOutput("stall_in_rdy", bus.in_rdy, 0);
    end
    align();
    bus.out_rdy = 1;
    waitIdle();

    // Reset mid-iteration aborts the point.
    applyStimulus(0, 0, 9);
    repeat (20) @(posedge clk);
    #3 rst = 1;
    #1;
    checkOutput("midrst_out_vld", bus.out_vld, 0);
    checkOutput("midrst_in_rdy", bus.in_rdy, 1);
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    checkOutput("postrst_in_rdy", bus.in_rdy, 1);
    align();
    applyStimulus(ONE, 0, 4);
    waitIdle();

    // Reduced iteration limit.
    runSmall(-ONE, 0, 16);
    runSmall(0, 0, 16);
    runSmall(ONE, 0, 2);

    // Randomized points with random clk_en and back-pressure.
    rand_en = 1;
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      longint xv, yv;
      if (i % 8 == 7) begin
        xv = wrap(longint'($urandom));
        yv = wrap(longint'($urandom));
      end else begin
        xv = -(5 * ONE) / 2 + longint'($urandom_range(0, 14680064));
        yv = -(5 * ONE) / 4 + longint'($urandom_range(0, 10485760));
      end
      applyStimulus(xv, yv, int'($urandom_range(0, 4095)));
    end
    waitIdle();

    // Small raster scan, addresses in raster order.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        applyStimulus(-2 * ONE + c * ((3 * ONE) / 8), -ONE + r * ((2 * ONE) / 6), r * 8 + c);
    waitIdle();

    rand_en = 0;
    rand_rdy = 0;
    bus.out_rdy = 1;
    align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
